// File: rtl/pll_mon_pkg.sv
// Shared FSM state codes and counter-width helpers for the PLL lock monitor.
// Pure declarations; no logic, no latency, no flow control.
package pll_mon_pkg;

   localparam logic [1:0] S_PLLRST = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_HOLD   = 2'd2;
   localparam logic [1:0] S_RUN    = 2'd3;

   // Bits needed to hold the values 0..n-1; never less than one bit.
   function automatic int ctr_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pll_lock_filt.sv
// Synchronizes the PLL LOCK pin and debounces it: slow assert, fast drop.
// Latency: rise 2+LOCK_FILT edges, fall 3 edges; free-running, no backpressure.
module pll_lock_filt
   import pll_mon_pkg::*;
#(
   parameter int LOCK_FILT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic lock,
   output logic lock_f
);

   localparam int FW = ctr_w(LOCK_FILT + 1);

   logic          ls1;
   logic          ls2;
   logic [FW-1:0] filt_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         ls1      <= 1'b0;
         ls2      <= 1'b0;
         filt_cnt <= '0;
         lock_f   <= 1'b0;
      end else begin
         ls1 <= lock;
         ls2 <= ls1;
         if (!ls2) begin
            filt_cnt <= '0;
            lock_f   <= 1'b0;
         end else if (filt_cnt != FW'(LOCK_FILT)) begin
            // Counter parks at LOCK_FILT so a long lock never wraps.
            filt_cnt <= filt_cnt + FW'(1);
            if (filt_cnt == FW'(LOCK_FILT - 1))
               lock_f <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/pll_lock_mon.sv
// PLL reset sequencer: pulses PLL_RST, retries on lock timeout, holds off SYS_RST, counts losses.
// Latency: LOCK fall to SYS_RST rise 4 edges; all outputs registered; no backpressure.
module pll_lock_mon
   import pll_mon_pkg::*;
#(
   parameter int LOCK_FILT    = 16,
   parameter int RST_HOLD     = 256,
   parameter int LOCK_TIMEOUT = 25000,
   parameter int PLLRST_LEN   = 32,
   parameter int CNT_W        = 8
) (
   input  logic             CLKI,
   input  logic             RST,
   input  logic             LOCK,
   input  logic             STICKY_CLR,
   output logic             PLL_RST,
   output logic             SYS_RST,
   output logic             READY,
   output logic [CNT_W-1:0] LOSS_CNT,
   output logic             LOSS_STICKY,
   output logic [CNT_W-1:0] RETRY_CNT
);

   // One shared phase counter; only one phase is ever being timed.
   localparam int TW = max_w(ctr_w(PLLRST_LEN),
                             max_w(ctr_w(LOCK_TIMEOUT), ctr_w(RST_HOLD)));

   logic          lock_f;
   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [TW-1:0] cnt;
   logic [TW-1:0] cnt_nxt;
   logic          loss_evt;
   logic          retry_evt;

   pll_lock_filt #(
      .LOCK_FILT (LOCK_FILT)
   ) u_filt (
      .clk    (CLKI),
      .rst    (RST),
      .lock   (LOCK),
      .lock_f (lock_f)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + TW'(1);
      loss_evt  = 1'b0;
      retry_evt = 1'b0;
      case (state)
         S_PLLRST: begin
            if (cnt == TW'(PLLRST_LEN - 1)) begin
               state_nxt = S_WAIT;
               cnt_nxt   = '0;
            end
         end
         S_WAIT: begin
            // Lock takes priority over a timeout landing on the same cycle.
            if (lock_f) begin
               state_nxt = S_HOLD;
               cnt_nxt   = '0;
            end else if (cnt == TW'(LOCK_TIMEOUT - 1)) begin
               state_nxt = S_PLLRST;
               cnt_nxt   = '0;
               retry_evt = 1'b1;
            end
         end
         S_HOLD: begin
            if (!lock_f) begin
               state_nxt = S_WAIT;
               cnt_nxt   = '0;
            end else if (cnt == TW'(RST_HOLD - 1)) begin
               state_nxt = S_RUN;
               cnt_nxt   = '0;
            end
         end
         S_RUN: begin
            cnt_nxt = '0;
            if (!lock_f) begin
               state_nxt = S_WAIT;
               loss_evt  = 1'b1;
            end
         end
         default: begin
            state_nxt = S_PLLRST;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge CLKI) begin
      if (RST) begin
         state       <= S_PLLRST;
         cnt         <= '0;
         PLL_RST     <= 1'b1;
         SYS_RST     <= 1'b1;
         READY       <= 1'b0;
         LOSS_CNT    <= '0;
         LOSS_STICKY <= 1'b0;
         RETRY_CNT   <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         PLL_RST <= (state_nxt == S_PLLRST);
         SYS_RST <= (state_nxt != S_RUN);
         READY   <= (state_nxt == S_RUN);
         if (loss_evt && (LOSS_CNT != '1))
            LOSS_CNT <= LOSS_CNT + CNT_W'(1);
         if (retry_evt && (RETRY_CNT != '1))
            RETRY_CNT <= RETRY_CNT + CNT_W'(1);
         if (loss_evt)
            LOSS_STICKY <= 1'b1;
         else if (STICKY_CLR)
            LOSS_STICKY <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pll_lock_mon.sv
// Bench for pll_lock_mon: directed scenarios then random LOCK/STICKY_CLR/RST traffic,
// every edge compared against a timestamp-based reference model.
module tb_pll_lock_mon;

   localparam int LF   = 4;
   localparam int HOLD = 8;
   localparam int TO   = 50;
   localparam int PLEN = 4;
   localparam int CW   = 4;
   localparam int SAT  = (1 << CW) - 1;
   localparam int HSZ  = 8192;

   localparam int P_RST  = 0;
   localparam int P_WAIT = 1;
   localparam int P_HOLD = 2;
   localparam int P_RUN  = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          lock = 1'b0;
   logic          sticky_clr = 1'b0;
   logic          pll_rst;
   logic          sys_rst;
   logic          ready;
   logic [CW-1:0] loss_cnt;
   logic          loss_sticky;
   logic [CW-1:0] retry_cnt;

   int n_chk = 0;
   int n_err = 0;

   // Reference model state: phase plus the edge at which it was entered.
   int n        = -1;
   int last_rst = -1;
   int ph       = P_RST;
   int t0       = 0;
   int m_loss   = 0;
   int m_retry  = 0;
   bit m_sticky = 1'b0;
   bit hist [HSZ];

   always #5 clk = ~clk;

   pll_lock_mon #(
      .LOCK_FILT    (LF),
      .RST_HOLD     (HOLD),
      .LOCK_TIMEOUT (TO),
      .PLLRST_LEN   (PLEN),
      .CNT_W        (CW)
   ) dut (
      .CLKI        (clk),
      .RST         (rst),
      .LOCK        (lock),
      .STICKY_CLR  (sticky_clr),
      .PLL_RST     (pll_rst),
      .SYS_RST     (sys_rst),
      .READY       (ready),
      .LOSS_CNT    (loss_cnt),
      .LOSS_STICKY (loss_sticky),
      .RETRY_CNT   (retry_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, n);
      end
   endtask

   // Filtered lock after edge m: LOCK sampled high on the LF edges ending two
   // edges earlier (synchronizer depth), none of them at or before a reset.
   function automatic bit lf_after(input int m);
      int first;
      first = m - 1 - LF;
      if (first < 0 || first <= last_rst)
         return 1'b0;
      for (int k = first; k <= m - 2; k++)
         if (!hist[k % HSZ])
            return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_edge(input logic r, input logic sc);
      bit lfp;
      bit loss_ev;
      lfp     = lf_after(n - 1);
      loss_ev = 1'b0;
      if (r) begin
         last_rst = n;
         ph       = P_RST;
         t0       = n;
         m_loss   = 0;
         m_retry  = 0;
         m_sticky = 1'b0;
      end else begin
         case (ph)
            P_RST: if (n - t0 == PLEN) begin ph = P_WAIT; t0 = n; end
            P_WAIT: begin
               if (lfp) begin
                  ph = P_HOLD; t0 = n;
               end else if (n - t0 == TO) begin
                  ph = P_RST; t0 = n;
                  if (m_retry < SAT) m_retry++;
               end
            end
            P_HOLD: begin
               if (!lfp) begin
                  ph = P_WAIT; t0 = n;
               end else if (n - t0 == HOLD) begin
                  ph = P_RUN; t0 = n;
               end
            end
            default: begin
               if (!lfp) begin
                  ph = P_WAIT; t0 = n; loss_ev = 1'b1;
                  if (m_loss < SAT) m_loss++;
               end
            end
         endcase
         if (loss_ev)
            m_sticky = 1'b1;
         else if (sc)
            m_sticky = 1'b0;
      end
   endtask

   task automatic step();
      logic r;
      logic sc;
      @(posedge clk);
      n++;
      r  = rst;
      sc = sticky_clr;
      hist[n % HSZ] = lock;
      #1;
      model_edge(r, sc);
      chk("pll_rst",     32'(pll_rst),     32'(ph == P_RST));
      chk("sys_rst",     32'(sys_rst),     32'(ph != P_RUN));
      chk("ready",       32'(ready),       32'(ph == P_RUN));
      chk("loss_cnt",    32'(loss_cnt),    32'(m_loss));
      chk("loss_sticky", 32'(loss_sticky), 32'(m_sticky));
      chk("retry_cnt",   32'(retry_cnt),   32'(m_retry));
   endtask

   task automatic wait_ready(input int lim, input string tag);
      int i;
      i = 0;
      while (ready !== 1'b1 && i < lim) begin
         step();
         i++;
      end
      chk(tag, 32'(ready), 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_pll_rst"}, 32'(pll_rst),     32'd1);
      chk({tag, "_sys_rst"}, 32'(sys_rst),     32'd1);
      chk({tag, "_ready"},   32'(ready),       32'd0);
      chk({tag, "_loss"},    32'(loss_cnt),    32'd0);
      chk({tag, "_sticky"},  32'(loss_sticky), 32'd0);
      chk({tag, "_retry"},   32'(retry_cnt),   32'd0);
   endtask

   // One-cycle LOCK drop from S_RUN; stops at the edge where the loss registers.
   task automatic drop_one(input logic clr_on_loss);
      lock = 1'b0; step();
      lock = 1'b1; step();
      step();
      chk("drop_sysrst_before", 32'(sys_rst), 32'd0);
      sticky_clr = clr_on_loss; step();
      sticky_clr = 1'b0;
      chk("drop_sysrst_after", 32'(sys_rst), 32'd1);
   endtask

   initial begin
      bit   sys_rst_dropped;
      int   dur;

      // Reset, then timeout/retry with LOCK held low
      rst = 1'b1; step(); step();
      check_reset_vals("rst0");
      rst = 1'b0;
      sys_rst_dropped = 1'b0;
      for (int i = 0; i < 16 * (PLEN + TO) + 20; i++) begin
         step();
         if (sys_rst !== 1'b1) sys_rst_dropped = 1'b1;
      end
      chk("retry_sat", 32'(retry_cnt), 32'(SAT));
      chk("retry_sysrst_held", 32'(sys_rst_dropped), 32'd0);

      // Nominal lock from a fresh reset
      rst = 1'b1; step();
      check_reset_vals("rst1");
      rst = 1'b0;
      repeat (10) step();
      lock = 1'b1;
      wait_ready(100, "nom_ready");
      chk("nom_retry", 32'(retry_cnt), 32'd0);

      // Loss in run, then relock
      drop_one(1'b0);
      chk("loss_cnt1", 32'(loss_cnt), 32'd1);
      chk("loss_sticky1", 32'(loss_sticky), 32'd1);
      wait_ready(40, "relock_ready");

      // Glitch in S_WAIT, then long low to reach the timeout
      lock = 1'b0; repeat (10) step();
      lock = 1'b1; repeat (3) step();
      lock = 1'b0; repeat (TO + 20) step();
      chk("glitch_no_ready", 32'(ready), 32'd0);

      // Drop during S_HOLD is not a loss
      lock = 1'b1; repeat (LF + 6) step();
      lock = 1'b0; step();
      lock = 1'b1;
      wait_ready(100, "hold_drop_ready");
      chk("hold_drop_loss", 32'(loss_cnt), 32'd2);

      // Sticky set wins over simultaneous clear, then a clean clear
      drop_one(1'b1);
      chk("sticky_prio", 32'(loss_sticky), 32'd1);
      wait_ready(40, "sticky_ready");
      sticky_clr = 1'b1; step();
      sticky_clr = 1'b0;
      chk("sticky_clr", 32'(loss_sticky), 32'd0);

      // Mid-operation reset from S_RUN with LOSS_CNT=3
      chk("pre_rst_loss", 32'(loss_cnt), 32'd3);
      chk("pre_rst_ready", 32'(ready), 32'd1);
      rst = 1'b1; step();
      rst = 1'b0;
      check_reset_vals("rst2");
      lock = 1'b0; repeat (10) step();
      lock = 1'b1;
      wait_ready(100, "rerun_ready");

      // Random traffic
      dur = 0;
      for (int i = 0; i < 3000; i++) begin
         if (dur == 0) begin
            lock = ~lock;
            dur  = ($urandom_range(0, 2) == 0) ? $urandom_range(20, 90)
                                               : $urandom_range(1, 7);
         end
         dur--;
         sticky_clr = ($urandom_range(0, 15) == 0);
         rst        = ($urandom_range(0, 799) == 0);
         step();
      end
      rst = 1'b0; sticky_clr = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
